aud_i2s_player: RTL
===================

// Module: aud_i2s_player
// PURPOSE
//  Downstream of the DSP stage: serialises its 16-bit sample (o_dac_data) onto the codec DACDAT line.
//  Output format is I2S: MSB first, one bit per i_clk, MSB appears one clock after each DACLRCK edge.
//  LRCK low selects the left channel, LRCK high selects the right channel.
//  The right channel carries the same sample (mono) or zeros.
//  Sits between the DSP stage and the WM8731 DAC pins; i_clk is the bit-clock domain the top level
//  uses to launch DACDAT.
// PARAMETERS
//  DATA_W   16   sample width; bits sent per channel slot
//  CNT_W     5   bit-counter width; must satisfy 2**CNT_W > DATA_W
// PORTS
//  i_clk          in   1       bit clock; all state updates on rising edge
//  i_rst_n        in   1       asynchronous active-low reset
//  i_en           in   1       play enable (level)
//  i_mono         in   1       1: right slot repeats the left sample; 0: right slot sends zeros
//  i_daclrck      in   1       codec DAC LR clock, synchronous to i_clk
//  i_dac_data     in   DATA_W  signed sample from the DSP stage; registered, stable between LRCK edges
//  o_aud_dacdat   out  1       serial data to codec
//  o_busy         out  1       high whenever state != S_IDLE
//  o_frame_done   out  1       1-cycle pulse after the last right-slot bit
//  o_short_slot   out  1       sticky: an LRCK edge arrived before DATA_W bits were sent
// BEHAVIOUR
//  Reset: state S_IDLE; prev_lrck, shift_r, bit_cnt, mono_r, and all outputs are 0.
//  Edge detection: prev_lrck <= i_daclrck every cycle.
//   - edge  = (i_daclrck != prev_lrck)
//   - fall  = edge & !i_daclrck (left-slot start); rise = edge & i_daclrck (right-slot start)
//  Output: o_aud_dacdat = shift_r[DATA_W-1] in S_SEND, else 0. It is a registered path, so the MSB
//   is visible the cycle after the edge is sampled (the I2S one-bit delay).
//  States:
//   S_IDLE: if i_en -> S_WAIT.
//   S_WAIT: wait for fall; a rise here is ignored so playback always starts on a left slot.
//     On fall: shift_r <= i_dac_data, mono_r <= i_mono, bit_cnt <= 0 -> S_SEND.
//   S_SEND: shift_r <= shift_r << 1, bit_cnt++ each cycle.
//     When bit_cnt == DATA_W-1 -> S_PAD; if the slot is right, pulse o_frame_done the same cycle.
//   S_PAD: drive 0 until the next edge.
//     On fall: reload from i_dac_data -> S_SEND.
//     On rise: if mono_r, reload with the left sample saved in hold_r, else load 0 -> S_SEND.
//  Left sample hold: hold_r captures i_dac_data on every fall, so mono right = the same frame's left sample.
//  Short slot: an edge in S_SEND (fewer than DATA_W bits sent) aborts the current word and sets o_short_slot.
//   The new slot is then loaded exactly as from S_PAD.
//  Latency: the sample present at the fall edge is the one sent, so DSP updates after the edge land one frame later.
//  i_en low: checked before all else in any non-idle state -> S_IDLE next cycle.
//   o_aud_dacdat goes 0 mid-word; o_short_slot clears; o_frame_done is not pulsed.
//  Simultaneous: i_en rising in the same cycle as a fall edge goes to S_WAIT only; sending starts on the next fall.
//  i_mono is sampled only at fall edges; changes mid-frame take effect next frame.
//  Async reset mid-word: immediate return to the reset values above; no partial word is resumed.
// STRUCTURE
//  Shared package aud_pkg:
//   - typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_PAD} player_state_t
//   - localparam AUD_DATA_W = 16
//  Sub-module aud_lrck_edge: registers LRCK, outputs edge/fall/rise; reusable by the recorder stage.
//  The serialiser FSM, counter and shift register stay in this module.
// TESTING
//  1 Reset then i_en=1, LRCK period 2x40 clk, i_dac_data=16'hA5C3, mono=0
//    -> left slot bits 1010_0101_1100_0011 starting 1 clk after fall; right slot all 0; pad 0.
//  2 Same with mono=1 -> right slot repeats 16'hA5C3; o_frame_done pulses once per frame,
//    the cycle after right bit 0.
//  3 i_en asserted while LRCK high -> no output until the next fall; the first rise is ignored.
//  4 Change i_dac_data to 16'h8001 two clocks after the fall edge
//    -> current slot still sends the old word; next frame sends 8001.
//  5 LRCK half-period 10 clk (< 16 bits) -> words truncated to 10 MSBs; o_short_slot sets and holds
//    until i_en drops.
//  6 Deassert i_en at bit 7, and separately pulse i_rst_n low at bit 7
//    -> o_aud_dacdat=0 next cycle (i_en) / immediately (reset); o_busy=0; restart aligns to the next fall.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared audio-path types and constants for the I2S player and recorder stages.
package aud_pkg;

   // Serialiser state: idle, armed for the first left slot, shifting a word, padding out a slot
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_PAD} player_state_t;

   localparam int AUD_DATA_W = 16;
   localparam int AUD_CNT_W  = 5;

endpackage

// File: rtl/aud_i2s_player_if.sv
// DSP-side sample/control inputs and codec-side serial outputs of the I2S player.
interface aud_i2s_player_if
   import aud_pkg::*;
#(
   parameter int DATA_W = AUD_DATA_W
);
   logic              i_en;
   logic              i_mono;
   logic              i_daclrck;
   logic [DATA_W-1:0] i_dac_data;
   logic              o_aud_dacdat;
   logic              o_busy;
   logic              o_frame_done;
   logic              o_short_slot;

   // Driver side: DSP stage / top level feeding the player
   modport master (
      output i_en, i_mono, i_daclrck, i_dac_data,
      input  o_aud_dacdat, o_busy, o_frame_done, o_short_slot
   );

   // Player side
   modport slave (
      input  i_en, i_mono, i_daclrck, i_dac_data,
      output o_aud_dacdat, o_busy, o_frame_done, o_short_slot
   );
endinterface

// File: rtl/aud_lrck_edge.sv
// LR-clock edge detector: compares LRCK with its value one clock earlier.
module aud_lrck_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_lrck,
   output logic o_edge,
   output logic o_fall,
   output logic o_rise
);
   logic prev_lrck_q;
   logic prev_lrck_d;

   // Next value of the delayed LRCK copy
   always_comb prev_lrck_d = i_lrck;

   // Delay LRCK by one clock so a level change shows up as an edge for exactly one cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) prev_lrck_q <= 1'b0;
      else          prev_lrck_q <= prev_lrck_d;
   end

   assign o_edge = i_lrck ^ prev_lrck_q;
   assign o_fall = o_edge & ~i_lrck;
   assign o_rise = o_edge & i_lrck;
endmodule

// File: rtl/aud_i2s_player.sv
// I2S DAC serialiser: sends one DATA_W-bit word MSB first per LRCK slot, left slot from
// the DSP sample, right slot either the same frame's left sample (mono) or zeros.
module aud_i2s_player
   import aud_pkg::*;
#(
   parameter int DATA_W = AUD_DATA_W,
   parameter int CNT_W  = AUD_CNT_W
) (
   input logic             i_clk,
   input logic             i_rst_n,
   aud_i2s_player_if.slave bus
);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic lrck_edge, lrck_fall, lrck_rise;

   aud_lrck_edge u_lrck_edge (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_lrck  (bus.i_daclrck),
      .o_edge  (lrck_edge),
      .o_fall  (lrck_fall),
      .o_rise  (lrck_rise)
   );

   player_state_t     state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              mono_q, mono_d;
   logic              slot_right_q, slot_right_d;
   logic              dacdat_q, dacdat_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;
   logic              short_q, short_d;
   logic              do_load;
   logic [DATA_W-1:0] load_word;

   // Word for a new slot: left takes the live sample, right repeats the held left sample or is silent
   assign load_word = lrck_fall ? bus.i_dac_data : (mono_q ? hold_q : '0);

   // Next-state logic for the serialiser FSM, shifter, counter and registered outputs
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      mono_d       = mono_q;
      slot_right_d = slot_right_q;
      short_d      = short_q;
      frame_done_d = 1'b0;
      do_load      = 1'b0;
      hold_d       = lrck_fall ? bus.i_dac_data : hold_q;

      if (state_q != S_IDLE && !bus.i_en) begin
         // Stopping abandons any word in flight and forgets a past short slot
         state_d = S_IDLE;
         short_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (bus.i_en) state_d = S_WAIT;
            // Rises are ignored here so the first word is always a left slot
            S_WAIT: do_load = lrck_fall;
            S_SEND: begin
               if (lrck_edge) begin
                  // An edge while bits remain truncates the word; on the last bit it is a normal slot end
                  if (bit_cnt_q != LAST_BIT) short_d = 1'b1;
                  else                       frame_done_d = slot_right_q;
                  do_load = 1'b1;
               end else begin
                  shift_d   = shift_q << 1;
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == LAST_BIT) begin
                     state_d      = S_PAD;
                     frame_done_d = slot_right_q;
                  end
               end
            end
            S_PAD:   do_load = lrck_edge;
            default: state_d = S_IDLE;
         endcase
      end

      if (do_load) begin
         state_d      = S_SEND;
         shift_d      = load_word;
         bit_cnt_d    = '0;
         slot_right_d = lrck_rise;
         if (lrck_fall) mono_d = bus.i_mono;
      end

      // Output follows the next register contents so the MSB lands one clock after the LRCK edge
      dacdat_d = (state_d == S_SEND) ? shift_d[DATA_W-1] : 1'b0;
      busy_d   = (state_d != S_IDLE);
   end

   // State and output registers; reset drops any partial word immediately
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         shift_q      <= '0;
         hold_q       <= '0;
         bit_cnt_q    <= '0;
         mono_q       <= 1'b0;
         slot_right_q <= 1'b0;
         dacdat_q     <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         short_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         hold_q       <= hold_d;
         bit_cnt_q    <= bit_cnt_d;
         mono_q       <= mono_d;
         slot_right_q <= slot_right_d;
         dacdat_q     <= dacdat_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         short_q      <= short_d;
      end
   end

   assign bus.o_aud_dacdat = dacdat_q;
   assign bus.o_busy       = busy_q;
   assign bus.o_frame_done = frame_done_q;
   assign bus.o_short_slot = short_q;
endmodule
